// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// Define BK_ADDER_PIPE_OVF_EN to enable the registered signed-overflow output path.

module bk_adder_pipe #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N = WIDTH + 1;  // prefix positions; position 0 carries c_eff
  localparam int D = $clog2(N);
  localparam int L = 2 * D - 1;

  typedef struct packed {
    logic [N-1:0]     g;
    logic [N-1:0]     pg;
    logic [WIDTH-1:0] p;
`ifdef BK_ADDER_PIPE_OVF_EN
    logic             a_msb;
`endif
  } pfx_t;

  // Last prefix level evaluated before register boundary k.
  function automatic int boundary(input int k);
    return (k * L + STAGES - 1) / STAGES;
  endfunction

  // Applies prefix levels lo+1..hi. Within one level the nodes written are never
  // read by another node of the same level, so in-place update is exact.
  function automatic pfx_t run_levels(input pfx_t din, input int lo, input int hi);
    pfx_t d;
    int   span;
    d = din;
    // NOTE: blocking assignments here are deliberate; each level must see the previous one.
    for (int l = 1; l <= L; l++) begin
      if (l > lo && l <= hi) begin
        if (l <= D) begin
          span = 1 << (l - 1);
          for (int j = 0; j < N; j++) begin
            if ((j + 1) % (2 * span) == 0) begin
              d.g[j]  = d.g[j] | (d.pg[j] & d.g[j-span]);
              d.pg[j] = d.pg[j] & d.pg[j-span];
            end
          end
        end else begin
          span = 1 << (2 * D - l - 1);
          for (int j = 0; j < N; j++) begin
            if (((j + 1) % (2 * span) == span) && (j >= 2 * span)) begin
              d.g[j]  = d.g[j] | (d.pg[j] & d.g[j-span]);
              d.pg[j] = d.pg[j] & d.pg[j-span];
            end
          end
        end
      end
    end
    return d;
  endfunction

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  pfx_t              pfx0;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] load;

  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    c_eff   = in_sub ^ in_cin;
    pfx0    = '0;
    pfx0.p  = in_a ^ b_eff;
    pfx0.g  = {in_a & b_eff, c_eff};
    pfx0.pg = {in_a ^ b_eff, 1'b0};
`ifdef BK_ADDER_PIPE_OVF_EN
    pfx0.a_msb = in_a[WIDTH-1];
`endif
  end

  // A stage may load when it, or any stage downstream of it, is empty, or the consumer takes.
  always_comb begin : p_load
    logic acc;
    load = '0;
    acc  = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc     = acc | ~v[s];
      load[s] = acc;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = boundary(s);
    localparam int HI = boundary(s + 1);

    pfx_t cur;
    pfx_t nxt;
    logic src_v;

    if (s == 0) begin : g_head
      assign cur   = pfx0;
      assign src_v = in_valid;
    end else begin : g_body
      assign cur   = g_stage[s-1].g_reg.q;
      assign src_v = v[s-1];
    end

    assign nxt = run_levels(cur, LO, HI);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[s] <= 1'b0;
      end else if (load[s]) begin
        v[s] <= src_v;
      end
    end

    if (s < STAGES - 1) begin : g_reg
      pfx_t q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (load[s] && src_v) begin
          q <= nxt;
        end
      end
    end else begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_sum  <= '0;
          out_cout <= 1'b0;
        end else if (load[s] && src_v) begin
          out_sum  <= nxt.p ^ nxt.g[WIDTH-1:0];
          out_cout <= nxt.g[WIDTH];
        end
      end
`ifdef BK_ADDER_PIPE_OVF_EN
      // Operand MSBs agree exactly when p_msb is 0; the sum MSB is then the carry into it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_ovf <= 1'b0;
        end else if (load[s] && src_v) begin
          out_ovf <= ~nxt.p[WIDTH-1] & (nxt.g[WIDTH-1] ^ nxt.a_msb);
        end
      end
`endif
    end
  end

`ifndef BK_ADDER_PIPE_OVF_EN
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed testbench for bk_adder_pipe (WIDTH=12, STAGES=2); hand-computed expectations.
// Overflow expectations apply only when BK_ADDER_PIPE_OVF_EN is defined.

module tb_bk_adder_pipe;

  localparam int W  = 12;
  localparam int S  = 2;
  localparam int NV = 13;
`ifdef BK_ADDER_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  bk_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vt [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    in_a     = vt[i].a;
    in_b     = vt[i].b;
    in_cin   = vt[i].cin;
    in_sub   = vt[i].sub;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic check_out(input int i);
    check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d_sum", i),   {20'd0, out_sum},   {20'd0, vt[i].sum});
    check($sformatf("v%0d_cout", i),  {31'd0, out_cout},  {31'd0, vt[i].cout});
    check($sformatf("v%0d_ovf", i),   {31'd0, out_ovf},   {31'd0, vt[i].ovf & OVF_ON});
  endtask

  initial begin
    //           a        b        cin   sub   sum      cout  ovf
    vt[0]  = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    vt[1]  = '{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0};
    vt[2]  = '{12'h007, 12'h005, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0};
    vt[3]  = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
    vt[4]  = '{12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0};
    vt[5]  = '{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
    vt[6]  = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
    vt[7]  = '{12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
    vt[8]  = '{12'h000, 12'h000, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0};
    vt[9]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0};
    vt[10] = '{12'hAAA, 12'h555, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0};
    vt[11] = '{12'hABC, 12'h123, 1'b0, 1'b1, 12'h999, 1'b1, 1'b0};
    vt[12] = '{12'h400, 12'h400, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd1);
    check("rst_sum",   {20'd0, out_sum},   32'd0);
    check("rst_cout",  {31'd0, out_cout},  32'd0);
    check("rst_ovf",   {31'd0, out_ovf},   32'd0);
    rst_n = 1'b1;

    // Single beat: result appears exactly S cycles after acceptance.
    @(negedge clk);
    drive(0);
    check("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idle();
    check("lat_early_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_out(0);

    // Back-to-back stream with the consumer always ready.
    for (int t = 0; t < NV + S; t++) begin
      @(negedge clk);
      if (t >= S) check_out(t - S);
      else        check($sformatf("strm_pre%0d", t), {31'd0, out_valid}, 32'd0);
      if (t < NV) drive(t);
      else        idle();
    end
    @(negedge clk);
    check("strm_drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure: two beats fill the pipe, the third waits; release drains in order.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3);
    check("bp_rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(4);
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(5);
    check("bp_rdy2", {31'd0, in_ready}, 32'd0);
    check_out(3);
    @(negedge clk);
    check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    check_out(3);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    check_out(3);
    @(negedge clk);
    idle();
    check_out(4);
    @(negedge clk);
    check_out(5);
    @(negedge clk);
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Reset with two beats in flight discards both.
    @(negedge clk);
    drive(9);
    @(negedge clk);
    drive(10);
    @(negedge clk);
    idle();
    check("rf_busy", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rf_valid", {31'd0, out_valid}, 32'd0);
    check("rf_ready", {31'd0, in_ready},  32'd1);
    check("rf_sum",   {20'd0, out_sum},   32'd0);
    check("rf_cout",  {31'd0, out_cout},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rf_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // Pipe still works after reset.
    drive(12);
    check("post_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idle();
    check("post_early_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_out(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
